spi_flash_cmd_decode: RTL and testbench
=======================================

// Module: spi_flash_cmd_decode
// PURPOSE
//  Flash command decoder downstream of qspi_sync: consumes byte/cmd/byte strobes, decodes 0x03 READ and
//  0xEB quad fast READ, assembles 24-bit address, issues byte reads to backing memory, returns data on byte_tx.
//  Sits between the QSPI slave front end and the SDRAM/BRAM read port of the flash emulator.
// PARAMETERS
//  ADDR_BITS    24     flash address width (address bytes = ADDR_BITS/8)
//  QUAD_DUMMY   2      dummy bytes after mode byte for 0xEB
//  FILL_BYTE    8'hFF  byte_tx value when no memory data is available
// PORTS
//  clk              in   1          system clock
//  reset            in   1          asynchronous, active-high reset
//  spi_byte         in   8          byte from qspi_sync; valid with either strobe
//  spi_cmd_strobe   in   1          first byte after CS falls (opcode)
//  spi_byte_strobe  in   1          any subsequent byte received
//  spi_byte_tx      out  8          next byte qspi_sync shifts out
//  rd_req           out  1          memory read request, held until rd_ack
//  rd_addr          out  ADDR_BITS  memory read address
//  rd_ack           in   1          one-cycle ack; rd_data valid same cycle
//  rd_data          in   8          memory read data
//  miss_count       out  16         saturating count of underruns
//  busy             out  1          high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, spi_byte_tx=FILL_BYTE, rd_req=0, rd_addr=0, miss_count=0, busy=0.
//  States: IDLE, ADDR, MODE, DUMMY, DATA, IGNORE.
//  spi_cmd_strobe in ANY state aborts current transaction: drop rd_req, clear byte counter, then decode:
//   0x03 -> ADDR (quad=0); 0xEB -> ADDR (quad=1); other opcode -> IGNORE.
//  ADDR: each byte strobe shifts byte into addr (MSB first); after ADDR_BITS/8 bytes: rd_addr<=addr,
//   rd_req<=1; next state DATA (0x03) or MODE (0xEB).
//  MODE: one byte strobe consumed (value ignored) -> DUMMY. DUMMY: QUAD_DUMMY strobes -> DATA
//   (QUAD_DUMMY=0 -> DATA directly from MODE).
//  rd_ack while rd_req: spi_byte_tx<=rd_data, rd_req<=0, pending flag set. One outstanding read max.
//  DATA, each byte strobe: byte just sent consumed; if pending flag clear (underrun) spi_byte_tx<=FILL_BYTE
//   and miss_count+=1 (saturates at 16'hFFFF). Then rd_addr<=rd_addr+1 (wraps 2^ADDR_BITS-1 -> 0),
//   rd_req<=1, pending cleared.
//  rd_ack and byte strobe same cycle: strobe wins for consumption (counts as underrun if pending was clear),
//   ack data is discarded, new request issued at incremented address.
//  Latency: rd_req rises 1 clk after last address byte strobe; byte_tx updates 1 clk after rd_ack.
//  IGNORE: all byte strobes ignored, spi_byte_tx=FILL_BYTE, no rd_req until next cmd strobe.
//  CS rise is implicit: decoder stays in state until next cmd strobe; rd_req may complete harmlessly.
//  Async reset mid-transaction returns to reset values immediately; outstanding ack after reset ignored.
// CONFIGURATION
//  SPI_DECODE_LOG_EN defined: adds outputs log_valid(1), log_cmd(8), log_addr(ADDR_BITS); log_valid pulses
//   one clk when address completes, with opcode and full address; reset 0/0/0.
//  Not defined: ports absent, no logging logic.
// STRUCTURE
//  Package spi_flash_pkg: CMD_READ=8'h03, CMD_QREAD=8'hEB, state enum dec_state_t, FILL_BYTE default.
//  One sub-module: spi_addr_shift (byte-wise address shift register + byte counter, done pulse).
// TESTING
//  03 A5 5A 01 02 -> rd_addr=0xA55A01 after 3rd addr byte, then 0xA55A02 on strobe of 0x02; byte_tx=rd_data.
//  03 22 11, CS high -> no rd_req issued; next cmd strobe returns state machine cleanly to ADDR/IGNORE.
//  EB A5 5A 01 02 10 20 30 -> rd_addr=0xA55A01, mode byte 0x02 ignored, 2 dummies, data from byte 0x30 on.
//  Memory never acks, 03 00 00 10 then 3 data strobes -> byte_tx=0xFF, miss_count=3, rd_req stays high.
//  03 FF FF FF + 2 data strobes -> rd_addr 0xFFFFFF -> 0x000000 -> 0x000001.
//  Opcode 0x9F + 4 bytes -> IGNORE, rd_req never asserted; async reset mid-ADDR -> all outputs reset values.

Source files
------------

// File: rtl/spi_flash_cmd_decode_pkg.sv
// spi_flash_pkg: opcodes, fill default and decoder state type (optional SPI_DECODE_LOG_EN logging lives in the top)
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] FILL_DEFAULT = 8'hFF;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_IGNORE} dec_state_t;
endpackage

// File: rtl/spi_flash_cmd_decode_if.sv
// spi_flash_cmd_decode_if: SPI byte side, memory read port and status; log signals only with SPI_DECODE_LOG_EN
interface spi_flash_cmd_decode_if #(parameter int ADDR_BITS = 24);
  logic [7:0] spi_byte;
  logic spi_cmd_strobe;
  logic spi_byte_strobe;
  logic [7:0] spi_byte_tx;
  logic rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic rd_ack;
  logic [7:0] rd_data;
  logic [15:0] miss_count;
  logic busy;
`ifdef SPI_DECODE_LOG_EN
  logic log_valid;
  logic [7:0] log_cmd;
  logic [ADDR_BITS-1:0] log_addr;
  modport slave(input spi_byte, spi_cmd_strobe, spi_byte_strobe, rd_ack, rd_data,
                output spi_byte_tx, rd_req, rd_addr, miss_count, busy, log_valid, log_cmd, log_addr);
  modport master(output spi_byte, spi_cmd_strobe, spi_byte_strobe, rd_ack, rd_data,
                 input spi_byte_tx, rd_req, rd_addr, miss_count, busy, log_valid, log_cmd, log_addr);
`else
  modport slave(input spi_byte, spi_cmd_strobe, spi_byte_strobe, rd_ack, rd_data,
                output spi_byte_tx, rd_req, rd_addr, miss_count, busy);
  modport master(output spi_byte, spi_cmd_strobe, spi_byte_strobe, rd_ack, rd_data,
                 input spi_byte_tx, rd_req, rd_addr, miss_count, busy);
`endif
endinterface

// File: rtl/spi_flash_cmd_decode_spi_addr_shift.sv
// spi_addr_shift: MSB-first byte-wise address assembly with byte counter and combinational done pulse
module spi_addr_shift #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [7:0]           i_byte,
  output logic [ADDR_BITS-1:0] o_addr_next,
  output logic                 o_done
);
  localparam int NB = ADDR_BITS / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  logic [ADDR_BITS-9:0] r_addr;
  logic [CW-1:0] r_cnt;
  assign o_addr_next = {r_addr, i_byte};
  assign o_done = i_en && r_cnt == LAST;
  // shift in one byte per enable; counter wraps after the last address byte
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_addr <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_addr <= o_addr_next[ADDR_BITS-9:0];
      r_cnt <= o_done ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/spi_flash_cmd_decode.sv
// spi_flash_cmd_decode: decodes 0x03/0xEB flash reads into byte memory reads; SPI_DECODE_LOG_EN adds a log port
module spi_flash_cmd_decode
  import spi_flash_pkg::*;
#(
  parameter int ADDR_BITS = 24,
  parameter int QUAD_DUMMY = 2,
  parameter logic [7:0] FILL_BYTE = FILL_DEFAULT
) (
  input logic clk,
  input logic reset,
  spi_flash_cmd_decode_if.slave bus
);
  localparam logic [7:0] DLAST = 8'(QUAD_DUMMY - 1);
  dec_state_t r_state, w_next;
  logic r_quad, r_pending, r_rd_req;
  logic [7:0] r_tx, r_dcnt;
  logic [ADDR_BITS-1:0] r_rd_addr, w_addr;
  logic [15:0] r_miss;
  logic w_cmd, w_byte, w_done, w_is_rd, w_take_ack;
  assign w_cmd = bus.spi_cmd_strobe;
  assign w_byte = bus.spi_byte_strobe && !w_cmd;
  assign w_is_rd = bus.spi_byte == CMD_READ || bus.spi_byte == CMD_QREAD;
  assign w_take_ack = bus.rd_ack && r_rd_req && !(w_byte && r_state == ST_DATA);
  spi_addr_shift #(.ADDR_BITS(ADDR_BITS)) u_shift (
    .clk(clk), .reset(reset), .i_clr(w_cmd), .i_en(w_byte && r_state == ST_ADDR),
    .i_byte(bus.spi_byte), .o_addr_next(w_addr), .o_done(w_done)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state: an opcode strobe always restarts, byte strobes walk the read phases
  always_comb begin
    w_next = r_state;
    if (w_cmd) w_next = w_is_rd ? ST_ADDR : ST_IGNORE;
    else if (w_byte)
      case (r_state)
        ST_ADDR:  if (w_done) w_next = r_quad ? ST_MODE : ST_DATA;
        ST_MODE:  w_next = QUAD_DUMMY == 0 ? ST_DATA : ST_DUMMY;
        ST_DUMMY: if (r_dcnt == DLAST) w_next = ST_DATA;
        default:  ;
      endcase
  end
  // read request, prefetched tx byte and underrun accounting; a strobe in DATA overrides a same-cycle ack
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_quad <= 1'b0;
      r_pending <= 1'b0;
      r_rd_req <= 1'b0;
      r_tx <= FILL_BYTE;
      r_dcnt <= '0;
      r_rd_addr <= '0;
      r_miss <= '0;
    end else if (w_cmd) begin
      r_quad <= bus.spi_byte == CMD_QREAD;
      r_pending <= 1'b0;
      r_rd_req <= 1'b0;
      r_tx <= FILL_BYTE;
      r_dcnt <= '0;
    end else begin
      if (w_take_ack) begin
        r_tx <= bus.rd_data;
        r_rd_req <= 1'b0;
        r_pending <= 1'b1;
      end
      if (w_byte && r_state == ST_DUMMY) r_dcnt <= r_dcnt + 8'd1;
      if (w_done) begin
        r_rd_addr <= w_addr;
        r_rd_req <= 1'b1;
        r_pending <= 1'b0;
      end
      if (w_byte && r_state == ST_DATA) begin
        if (!r_pending) begin
          r_tx <= FILL_BYTE;
          r_miss <= r_miss == 16'hFFFF ? r_miss : r_miss + 16'd1;
        end
        r_rd_addr <= r_rd_addr + ADDR_BITS'(1);
        r_rd_req <= 1'b1;
        r_pending <= 1'b0;
      end
    end
  assign bus.spi_byte_tx = r_tx;
  assign bus.rd_req = r_rd_req;
  assign bus.rd_addr = r_rd_addr;
  assign bus.miss_count = r_miss;
  assign bus.busy = r_state != ST_IDLE;
`ifdef SPI_DECODE_LOG_EN
  logic [7:0] r_op, r_log_cmd;
  logic r_log_valid;
  logic [ADDR_BITS-1:0] r_log_addr;
  // remember the opcode and publish it with the full address when the address completes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_op <= '0;
      r_log_valid <= 1'b0;
      r_log_cmd <= '0;
      r_log_addr <= '0;
    end else begin
      r_log_valid <= w_done;
      if (w_cmd) r_op <= bus.spi_byte;
      if (w_done) begin
        r_log_cmd <= r_op;
        r_log_addr <= w_addr;
      end
    end
  assign bus.log_valid = r_log_valid;
  assign bus.log_cmd = r_log_cmd;
  assign bus.log_addr = r_log_addr;
`endif
endmodule

// File: tb/tb_spi_flash_cmd_decode.sv
// tb_spi_flash_cmd_decode: directed transactions against a byte-index transaction model plus literal checks
module tb_spi_flash_cmd_decode;
  localparam int AB = 24;
  localparam int QD = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  spi_flash_cmd_decode_if #(.ADDR_BITS(AB)) bus();
  spi_flash_cmd_decode #(.ADDR_BITS(AB), .QUAD_DUMMY(QD), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int vectors = 0;
  int errors = 0;
  logic [7:0] m_op, m_tx;
  logic m_act, m_req, m_pend;
  int m_n, lat_cnt, lat;
  logic [23:0] m_sh, m_addr;
  logic [15:0] m_miss;
  bit mem_on, force_ack;
  function automatic logic [7:0] mem(input logic [23:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic compare_all();
    check("byte_tx", {24'd0, bus.spi_byte_tx}, {24'd0, m_tx});
    check("rd_req", {31'd0, bus.rd_req}, {31'd0, m_req});
    check("rd_addr", {8'd0, bus.rd_addr}, {8'd0, m_addr});
    check("miss_count", {16'd0, bus.miss_count}, {16'd0, m_miss});
    check("busy", {31'd0, bus.busy}, {31'd0, m_act});
  endtask
  task automatic model_reset();
    m_act = 0; m_req = 0; m_pend = 0; m_tx = 8'hFF; m_addr = 0; m_miss = 0;
    m_n = 0; m_sh = 0; m_op = 0; lat_cnt = 0;
  endtask
  task automatic step(input bit c, input bit bs, input logic [7:0] b);
    logic ack, ign, indata, issued;
    int ds;
    ack = force_ack || (mem_on && m_req && lat_cnt >= lat);
    bus.spi_cmd_strobe = c;
    bus.spi_byte_strobe = bs;
    bus.spi_byte = b;
    bus.rd_ack = ack;
    bus.rd_data = mem(m_addr);
    ign = !(m_op == 8'h03 || m_op == 8'hEB);
    ds = m_op == 8'h03 ? 3 : 4 + QD;
    indata = m_act && !ign && m_n >= ds;
    issued = 0;
    if (c) begin
      m_act = 1; m_op = b; m_n = 0; m_req = 0; m_pend = 0; m_tx = 8'hFF;
    end else begin
      if (ack && m_req && !(bs && indata)) begin
        m_tx = mem(m_addr); m_req = 0; m_pend = 1;
      end
      if (bs && m_act && !ign) begin
        if (m_n < 3) begin
          m_sh = {m_sh[15:0], b};
          if (m_n == 2) begin
            m_addr = m_sh; m_req = 1; m_pend = 0; issued = 1;
          end
        end else if (indata) begin
          if (!m_pend) begin
            m_tx = 8'hFF;
            if (m_miss != 16'hFFFF) m_miss++;
          end
          m_addr++; m_req = 1; m_pend = 0; issued = 1;
        end
        m_n++;
      end
    end
    if (issued) lat_cnt = 0;
    else if (m_req) lat_cnt++;
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask
  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    compare_all();
  endtask
  initial begin
    bus.spi_byte = 0; bus.spi_cmd_strobe = 0; bus.spi_byte_strobe = 0; bus.rd_ack = 0; bus.rd_data = 0;
    mem_on = 1; lat = 1; force_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {24'd0, bus.spi_byte_tx}, 32'hFF);
    check("rst_req", {31'd0, bus.rd_req}, 32'd0);
    check("rst_addr", {8'd0, bus.rd_addr}, 32'd0);
    check("rst_miss", {16'd0, bus.miss_count}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 0;
    step(1, 0, 8'h03); step(0, 1, 8'hA5); step(0, 1, 8'h5A); step(0, 1, 8'h01);
    check("t1_addr", {8'd0, bus.rd_addr}, 32'hA55A01);
    check("t1_req", {31'd0, bus.rd_req}, 32'd1);
    idle(2);
    check("t1_tx", {24'd0, bus.spi_byte_tx}, 32'h3D);
    step(0, 1, 8'h02);
    check("t1_addr2", {8'd0, bus.rd_addr}, 32'hA55A02);
    check("t1_miss", {16'd0, bus.miss_count}, 32'd0);
    idle(3);
    step(1, 0, 8'h03); step(0, 1, 8'h22); step(0, 1, 8'h11);
    idle(4);
    check("t2_noreq", {31'd0, bus.rd_req}, 32'd0);
    lat = 0;
    step(1, 0, 8'hEB); step(0, 1, 8'hA5); step(0, 1, 8'h5A); step(0, 1, 8'h01);
    check("t3_addr", {8'd0, bus.rd_addr}, 32'hA55A01);
    step(0, 1, 8'h02); step(0, 1, 8'h10); step(0, 1, 8'h20);
    check("t3_addr_hold", {8'd0, bus.rd_addr}, 32'hA55A01);
    step(0, 1, 8'h30);
    check("t3_addr2", {8'd0, bus.rd_addr}, 32'hA55A02);
    idle(1);
    check("t3_tx", {24'd0, bus.spi_byte_tx}, 32'h3E);
    check("t3_miss", {16'd0, bus.miss_count}, 32'd0);
    do_reset();
    mem_on = 0;
    step(1, 0, 8'h03); step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h10);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h55);
    check("t4_miss", {16'd0, bus.miss_count}, 32'd3);
    check("t4_tx", {24'd0, bus.spi_byte_tx}, 32'hFF);
    check("t4_req", {31'd0, bus.rd_req}, 32'd1);
    check("t4_addr", {8'd0, bus.rd_addr}, 32'h000013);
    step(1, 0, 8'h03);
    check("t4_abort", {31'd0, bus.rd_req}, 32'd0);
    mem_on = 1;
    do_reset();
    step(1, 0, 8'h03); step(0, 1, 8'hFF); step(0, 1, 8'hFF); step(0, 1, 8'hFF);
    check("t5_addr", {8'd0, bus.rd_addr}, 32'hFFFFFF);
    step(0, 1, 8'h00);
    check("t5_wrap", {8'd0, bus.rd_addr}, 32'h000000);
    step(0, 1, 8'h00);
    check("t5_addr1", {8'd0, bus.rd_addr}, 32'h000001);
    check("t5_miss", {16'd0, bus.miss_count}, 32'd2);
    idle(1);
    check("t5_tx", {24'd0, bus.spi_byte_tx}, 32'h3D);
    do_reset();
    step(1, 0, 8'h9F); step(0, 1, 8'h03); step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h01);
    idle(2);
    check("t6_req", {31'd0, bus.rd_req}, 32'd0);
    check("t6_tx", {24'd0, bus.spi_byte_tx}, 32'hFF);
    check("t6_busy", {31'd0, bus.busy}, 32'd1);
    lat = 1;
    step(1, 0, 8'h03); step(0, 1, 8'h12); step(0, 1, 8'h34);
    #1 reset = 1;
    #1;
    check("t7_tx", {24'd0, bus.spi_byte_tx}, 32'hFF);
    check("t7_req", {31'd0, bus.rd_req}, 32'd0);
    check("t7_addr", {8'd0, bus.rd_addr}, 32'd0);
    check("t7_busy", {31'd0, bus.busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    mem_on = 0;
    step(1, 0, 8'h03); step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h07);
    #1 reset = 1;
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    force_ack = 1;
    step(0, 0, 8'h00);
    force_ack = 0;
    check("t7_stale_ack", {24'd0, bus.spi_byte_tx}, 32'hFF);
    step(0, 1, 8'h44);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
